button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions raw asynchronous board inputs (4 BUTTONS + 2 SWITCHES) before the adder top-level consumes them.
//  Per channel: 2-flop synchronizer -> sample-tick saturating debouncer -> stable level + rising-edge pulse.
//  Outputs drive the adder operand buses in place of raw pins: cond_level = {SWITCHES[1:0], BUTTONS[3:0]}.
// PARAMETERS
//  WIDTH           6        number of independent input channels
//  SAMPLE_CNT_MAX  62500    clk cycles per debounce sample tick (125 MHz -> 0.5 ms); >= 2
//  PULSE_CNT_MAX   200      consecutive high samples required to declare a channel stable; >= 1
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  raw_in       in   WIDTH  unsynchronized pin levels, {SWITCHES, BUTTONS}
//  cond_level   out  WIDTH  debounced level, 1 = stably asserted
//  rise_pulse   out  WIDTH  1-cycle pulse on cond_level 0->1
//  fall_pulse   out  WIDTH  1-cycle pulse on cond_level 1->0 (see CONFIGURATION)
// BEHAVIOUR
//  Reset: one clock; rst_n asynchronous, active-low. While rst_n=0 all flops clear: sync stages, sample
//   counter, per-channel counters, prev-level regs; cond_level, rise_pulse and fall_pulse are all 0.
//  Synchronizer: raw_in -> s1 -> s2, 2 cycles of latency; all downstream logic sees only s2.
//  Sample counter: counts 0..SAMPLE_CNT_MAX-1, wraps to 0; sample_tick = (count == SAMPLE_CNT_MAX-1), 1 cycle.
//  Channel counter cnt[i], width $clog2(PULSE_CNT_MAX+1), priority order:
//   1. s2[i]==0                               -> cnt <= 0 on every cycle, independent of sample_tick
//   2. s2[i]==1 && sample_tick && cnt<MAX     -> cnt <= cnt+1
//   3. otherwise                              -> hold (saturates at PULSE_CNT_MAX; never wraps)
//  cond_level[i] = (cnt[i] == PULSE_CNT_MAX), decoded from registers only; no raw-path glitches.
//  Asymmetric by design: assert needs PULSE_CNT_MAX consecutive high ticks; any single low synced cycle
//   releases. Release latency = 3 cycles from raw fall (2 sync + 1 clear).
//  Assert latency from raw rise: min 2+(PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1, max 2+PULSE_CNT_MAX*SAMPLE_CNT_MAX.
//  prev[i] <= cond_level[i]; rise_pulse[i] = cond_level[i] & ~prev[i], exactly 1 cycle per assertion.
//  Channels are fully independent and share only sample_tick; simultaneous edges on several channels
//   pulse in the same cycle.
//  Reset mid-operation: outputs drop immediately. No pulse may fire on reset release even if inputs are
//   held high; a held input must re-debounce the full interval, then rise_pulse fires once.
//  Input held indefinitely: cnt stays saturated; no further pulses.
// CONFIGURATION
//  BTN_COND_FALL_EDGE_EN defined:   fall_pulse[i] = ~cond_level[i] & prev[i], 1 cycle per release.
//  BTN_COND_FALL_EDGE_EN undefined: fall_pulse tied to 0; falling-edge logic not synthesized.
//  Port list is identical in both builds.
// STRUCTURE
//  Shared package board_io_pkg:
//   - BTN_COUNT=4, SW_COUNT=6-4=2, IO_WIDTH=6
//   - index constants BTN0_IDX..BTN3_IDX, SW0_IDX, SW1_IDX
//   - default tick constants for a 125 MHz clock
//  Top-level holds the synchronizers and the single shared sample counter.
//  Sub-module debounce_channel (one instance per channel, generate loop):
//   - in: clk, rst_n, sync_in, sample_tick
//   - out: level, rise, fall
//   - contains cnt, prev and the edge logic
// TESTING (bench params: SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=6; run both macro builds)
//  1. raw_in[0] 0->1, held -> cond_level[0]=1 within 11..14 cycles; rise_pulse[0] high exactly 1 cycle.
//  2. raw_in[1] toggles every 3 cycles for 60 cycles -> cond_level[1] and rise_pulse[1] stay 0 throughout.
//  3. Stable channel 0, raw_in[0] 1->0 -> cond_level[0]=0 after 3 cycles.
//     fall_pulse[0] 1 cycle with the macro, always 0 without it; no rise_pulse.
//  4. rst_n low for 2 cycles, once mid-count and once with cond_level=6'h3F -> all outputs 0 asynchronously.
//     After release, inputs held -> no pulse for >=10 cycles, then one rise_pulse per channel.
//  5. raw_in=6'b000101 in one cycle -> rise_pulse=6'b000101 in a single cycle, all other bits 0.
//  6. raw_in[5] held 1000 cycles -> exactly one rise_pulse[5]; cond_level[5] stays 1, counter never wraps.

Source files
------------

// File: rtl/board_io_pkg.sv
// Board I/O constants shared by the input conditioner and the adder top-level.
// Pin order on the conditioned bus is {SWITCHES[1:0], BUTTONS[3:0]}.
package board_io_pkg;
  localparam int BTN_COUNT = 4;
  localparam int IO_WIDTH  = 6;
  localparam int SW_COUNT  = IO_WIDTH - BTN_COUNT;

  localparam int BTN0_IDX = 0;
  localparam int BTN1_IDX = 1;
  localparam int BTN2_IDX = 2;
  localparam int BTN3_IDX = 3;
  localparam int SW0_IDX  = BTN_COUNT;
  localparam int SW1_IDX  = BTN_COUNT + 1;

  // 125 MHz: 0.5 ms sample tick, 200 ticks (100 ms) to declare a level stable
  localparam int DEF_SAMPLE_CNT_MAX = 62500;
  localparam int DEF_PULSE_CNT_MAX  = 200;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_out_t;
endpackage

// File: rtl/button_conditioner_if.sv
// Raw-pin / conditioned-output bundle between the board pins and the conditioner.
interface button_conditioner_if
  import board_io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] cond_level;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (output raw_in, input cond_level, rise_pulse, fall_pulse);
  modport slave  (input raw_in, output cond_level, rise_pulse, fall_pulse);
endinterface

// File: rtl/debounce_channel.sv
// One debounce lane: saturating count of consecutive high sample ticks, level decode and edge pulses.
// Optional BTN_COND_FALL_EDGE_EN enables the release pulse; otherwise fall is tied low.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int PULSE_CNT_MAX = DEF_PULSE_CNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  input  logic sample_tick,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PULSE_CNT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;

  // A single low synced cycle releases; assertion needs an unbroken run of ticks.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync_in)                           cnt_d = '0;
    else if (sample_tick && cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    level  = (cnt_q == CNT_MAX);
    prev_d = level;
    rise   = level & ~prev_q;
`ifdef BTN_COND_FALL_EDGE_EN
    fall   = ~level & prev_q;
`else
    fall   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// Board input conditioner: 2-flop sync per pin, one shared sample tick, per-channel debouncer.
// Build option BTN_COND_FALL_EDGE_EN enables fall_pulse; default build ties it to 0.
module button_conditioner
  import board_io_pkg::*;
#(
  parameter int WIDTH          = IO_WIDTH,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave io
);
  localparam int SCW = (SAMPLE_CNT_MAX > 2) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);

  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [SCW-1:0]   samp_cnt_q, samp_cnt_d;
  logic             sample_tick;

  always_comb begin
    s1_d        = io.raw_in;
    s2_d        = s1_q;
    sample_tick = (samp_cnt_q == SAMPLE_LAST);
    samp_cnt_d  = sample_tick ? '0 : samp_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      samp_cnt_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      samp_cnt_q <= samp_cnt_d;
    end
  end

  chan_out_t [WIDTH-1:0] ch_out;
  logic      [WIDTH-1:0] lvl_w, rise_w, fall_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(.PULSE_CNT_MAX(PULSE_CNT_MAX)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_in    (s2_q[i]),
      .sample_tick(sample_tick),
      .level      (ch_out[i].level),
      .rise       (ch_out[i].rise),
      .fall       (ch_out[i].fall)
    );
    assign lvl_w[i]  = ch_out[i].level;
    assign rise_w[i] = ch_out[i].rise;
    assign fall_w[i] = ch_out[i].fall;
  end

  assign io.cond_level = lvl_w;
  assign io.rise_pulse = rise_w;
  assign io.fall_pulse = fall_w;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=6.
// Builds with or without BTN_COND_FALL_EDGE_EN; fall_pulse expectation follows the macro.
module tb_button_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef BTN_COND_FALL_EDGE_EN
  localparam logic FALL_EXP = 1'b1;
`else
  localparam logic FALL_EXP = 1'b0;
`endif

  button_conditioner_if #(.WIDTH(6)) io ();

  button_conditioner #(.WIDTH(6), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After a reset release with inputs held: first pulse exactly 12 edges later, once, no fall.
  task automatic watch_rise(input string tag, input logic [5:0] exp_val);
    int first = 0;
    int npulse = 0;
    int nfall = 0;
    logic [5:0] val = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (io.rise_pulse != 0) begin
        if (first == 0) begin
          first = n;
          val   = io.rise_pulse;
        end
        npulse++;
      end
      if (io.fall_pulse != 0) nfall++;
    end
    chk({tag, "_first"}, first, 12);
    chk({tag, "_val"}, val, exp_val);
    chk({tag, "_npulse"}, npulse, 1);
    chk({tag, "_nfall"}, nfall, 0);
  endtask

  initial begin
    int lat, seen, rc, low, first, npulse;
    logic [5:0] val;

    io.raw_in = '0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_level", io.cond_level, 6'h00);
    chk("rst_rise", io.rise_pulse, 6'h00);
    chk("rst_fall", io.fall_pulse, 6'h00);
    rst_n = 1'b1;
    repeat (5) step();

    // 1: single channel assert latency and one-cycle rise
    io.raw_in[0] = 1'b1;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (io.cond_level[0]) begin
        lat = n;
        break;
      end
    end
    chk("t1_lat_in_11_14", (lat >= 11 && lat <= 14), 1);
    chk("t1_rise_at_assert", io.rise_pulse, 6'h01);
    step();
    chk("t1_rise_one_cycle", io.rise_pulse, 6'h00);
    chk("t1_level_held", io.cond_level, 6'h01);

    // 2: bouncing channel never asserts
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      if (n % 3 == 0) io.raw_in[1] = ~io.raw_in[1];
      step();
      if (io.cond_level[1] || io.rise_pulse[1]) seen++;
    end
    io.raw_in[1] = 1'b0;
    repeat (3) step();
    chk("t2_bounce_quiet", seen, 0);

    // 3: release after 3 cycles
    io.raw_in[0] = 1'b0;
    step();
    step();
    chk("t3_level_still_hi", io.cond_level[0], 1'b1);
    step();
    chk("t3_level_lo", io.cond_level[0], 1'b0);
    chk("t3_fall", io.fall_pulse, {5'b0, FALL_EXP});
    chk("t3_no_rise", io.rise_pulse, 6'h00);
    step();
    chk("t3_fall_one_cycle", io.fall_pulse, 6'h00);

    // 4a: reset mid-count
    io.raw_in = 6'h3F;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("t4a_rst_level", io.cond_level, 6'h00);
    chk("t4a_rst_rise", io.rise_pulse, 6'h00);
    step();
    step();
    rst_n = 1'b1;
    watch_rise("t4a", 6'h3F);

    // 4b: reset with every channel asserted
    chk("t4b_all_level", io.cond_level, 6'h3F);
    rst_n = 1'b0;
    #1;
    chk("t4b_rst_level", io.cond_level, 6'h00);
    chk("t4b_rst_rise", io.rise_pulse, 6'h00);
    chk("t4b_rst_fall", io.fall_pulse, 6'h00);
    step();
    step();
    rst_n = 1'b1;
    watch_rise("t4b", 6'h3F);

    // 5: simultaneous edges pulse together
    io.raw_in = '0;
    repeat (4) step();
    io.raw_in = 6'b000101;
    first = 0;
    npulse = 0;
    val = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (io.rise_pulse != 0) begin
        if (first == 0) begin
          first = n;
          val   = io.rise_pulse;
        end
        npulse++;
      end
    end
    chk("t5_val", val, 6'h05);
    chk("t5_npulse", npulse, 1);
    chk("t5_level", io.cond_level, 6'h05);

    // 6: long hold saturates, single pulse
    io.raw_in = 6'b100000;
    rc = 0;
    low = 0;
    for (int n = 0; n < 1000; n++) begin
      step();
      if (io.rise_pulse[5]) rc++;
      if (rc > 0 && !io.cond_level[5]) low++;
    end
    chk("t6_npulse", rc, 1);
    chk("t6_never_drop", low, 0);
    chk("t6_level_end", io.cond_level, 6'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
